// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP scan sequencer (states, scan direction, strobe bundle).
// Latency: none, declarations and a pure decode function only.
// Backpressure: not applicable; the optional stall lives in lbp_scan_ctrl.
package lbp_pkg;

    localparam int IMG_W     = 128;
    localparam int AXIS_W    = 7;
    localparam int FIRST_CTR = 1;
    localparam int LAST_CTR  = IMG_W - 2;
    localparam int INIT_LEN  = 10;
    localparam int MOVE_LEN  = 4;
    localparam int CYC_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CALC,
        MV_R,
        MV_D,
        MV_L,
        DONE
    } state_t;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_t;

    typedef struct packed {
        logic gray_req;
        logic initialize;
        logic right;
        logic down;
        logic left;
        logic lbp_valid;
        logic finish;
    } strobe_t;

    // Strobe pattern for a given phase; the last slot of INIT/MOVE is the
    // memory read latency slot, so no fetch is issued there.
    function automatic strobe_t decode_strobes(input state_t st, input logic [CYC_W-1:0] cyc);
        strobe_t s;
        s = '0;
        case (st)
            INIT: begin
                s.initialize = 1'b1;
                s.gray_req   = (cyc < CYC_W'(INIT_LEN - 1));
            end
            CALC: s.lbp_valid = 1'b1;
            MV_R: begin
                s.right    = 1'b1;
                s.gray_req = (cyc < CYC_W'(MOVE_LEN - 1));
            end
            MV_D: begin
                s.down     = 1'b1;
                s.gray_req = (cyc < CYC_W'(MOVE_LEN - 1));
            end
            MV_L: begin
                s.left     = 1'b1;
                s.gray_req = (cyc < CYC_W'(MOVE_LEN - 1));
            end
            DONE: s.finish = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lbp_pos_cnt.sv
// Window-center position register (row, col, snake direction) with step commands and edge flags.
// Latency: a command updates the position on the next rising edge; flags are combinational.
// Backpressure: none; the caller only issues a command when a move really completes.
module lbp_pos_cnt #(
    parameter int IMG_W  = 128,
    parameter int AXIS_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              down,
    output logic [AXIS_W-1:0] row,
    output logic [AXIS_W-1:0] col,
    output lbp_pkg::dir_t     dir,
    output logic              at_right_edge,
    output logic              at_left_edge,
    output logic              at_last
);
    import lbp_pkg::*;

    localparam logic [AXIS_W-1:0] FIRST = AXIS_W'(1);
    localparam logic [AXIS_W-1:0] LAST  = AXIS_W'(IMG_W - 2);

    // Position update; a row step also reverses the horizontal direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            row <= FIRST;
            col <= FIRST;
            dir <= RIGHT;
        end else if (down) begin
            row <= row + 1'b1;
            dir <= (dir == RIGHT) ? LEFT : RIGHT;
        end else if (inc) begin
            col <= col + 1'b1;
        end else if (dec) begin
            col <= col - 1'b1;
        end
    end

    assign at_right_edge = (col == LAST);
    assign at_left_edge  = (col == FIRST);
    // Last row, sitting at the end of that row in the current travel direction.
    assign at_last       = (row == LAST) && ((dir == LEFT) ? at_left_edge : at_right_edge);

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Snake-order scan sequencer for the LBP window: drives the address-generator phases and lbp_valid.
// Latency: strobes are registered and line up with state/cycle; INIT is 10 cycles, each move 4, CALC 1.
// Backpressure: none by default; with LBP_SCAN_HOLD_EN an input 'hold' freezes the scan and masks strobes.
module lbp_scan_ctrl #(
    parameter int IMG_W  = 128,
    parameter int AXIS_W = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      gray_ready,
`ifdef LBP_SCAN_HOLD_EN
    input  logic                      hold,
`endif
    output logic                      gray_req,
    output logic                      initialize,
    output logic                      right,
    output logic                      down,
    output logic                      left,
    output logic [lbp_pkg::CYC_W-1:0] cycle,
    output logic [2*AXIS_W-1:0]       lbp_addr,
    output logic                      lbp_valid,
    output logic                      finish
);
    import lbp_pkg::*;

    localparam logic [CYC_W-1:0] INIT_LAST = CYC_W'(INIT_LEN - 1);
    localparam logic [CYC_W-1:0] MOVE_LAST = CYC_W'(MOVE_LEN - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CYC_W-1:0]  cycle_q;
    logic [CYC_W-1:0]  cycle_d;
    strobe_t           strb_q;
    strobe_t           strb_d;
    logic              stall;
    logic [AXIS_W-1:0] row;
    logic [AXIS_W-1:0] col;
    dir_t              dir;
    logic              at_right_edge;
    logic              at_left_edge;
    logic              at_last;
    logic              move_done;

`ifdef LBP_SCAN_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    // The center moves only on the edge that leaves the last move cycle, so
    // the address generator sees the old center as its base for the whole move.
    assign move_done = !stall && (cycle_q == MOVE_LAST);

    lbp_pos_cnt #(
        .IMG_W  (IMG_W),
        .AXIS_W (AXIS_W)
    ) u_pos (
        .clk           (clk),
        .reset         (reset),
        .inc           (move_done && (state_q == MV_R)),
        .dec           (move_done && (state_q == MV_L)),
        .down          (move_done && (state_q == MV_D)),
        .row           (row),
        .col           (col),
        .dir           (dir),
        .at_right_edge (at_right_edge),
        .at_left_edge  (at_left_edge),
        .at_last       (at_last)
    );

    // Next phase and phase counter; a stall simply holds the current phase.
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    cycle_d = '0;
                    if (gray_ready) begin
                        state_d = INIT;
                    end
                end
                INIT: begin
                    if (cycle_q == INIT_LAST) begin
                        state_d = CALC;
                        cycle_d = '0;
                    end else if (cycle_q > INIT_LAST) begin
                        state_d = IDLE;
                        cycle_d = '0;
                    end else begin
                        cycle_d = cycle_q + 1'b1;
                    end
                end
                CALC: begin
                    cycle_d = '0;
                    if (at_last) begin
                        state_d = DONE;
                    end else if (dir == RIGHT) begin
                        state_d = at_right_edge ? MV_D : MV_R;
                    end else begin
                        state_d = at_left_edge ? MV_D : MV_L;
                    end
                end
                MV_R, MV_D, MV_L: begin
                    if (cycle_q == MOVE_LAST) begin
                        state_d = CALC;
                        cycle_d = '0;
                    end else if (cycle_q > MOVE_LAST) begin
                        state_d = IDLE;
                        cycle_d = '0;
                    end else begin
                        cycle_d = cycle_q + 1'b1;
                    end
                end
                DONE: cycle_d = '0;
                default: begin
                    state_d = IDLE;
                    cycle_d = '0;
                end
            endcase
        end
        strb_d = decode_strobes(state_d, cycle_d);
    end

    // State, counter and strobe registers; strobes are decoded from the next
    // phase so they line up with state/cycle without a combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cycle_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            strb_q  <= strb_d;
        end
    end

    assign gray_req   = strb_q.gray_req   & ~stall;
    assign initialize = strb_q.initialize & ~stall;
    assign right      = strb_q.right      & ~stall;
    assign down       = strb_q.down       & ~stall;
    assign left       = strb_q.left       & ~stall;
    assign lbp_valid  = strb_q.lbp_valid  & ~stall;
    assign finish     = strb_q.finish;
    assign cycle      = cycle_q;
    assign lbp_addr   = {row, col};

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Directed bench for lbp_scan_ctrl: start-up, first moves, row turns, mid-scan reset, full scan.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises 'hold' only when LBP_SCAN_HOLD_EN is defined.
module tb_lbp_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        gray_ready;
`ifdef LBP_SCAN_HOLD_EN
    logic        hold;
`endif
    logic        gray_req;
    logic        initialize;
    logic        right;
    logic        down;
    logic        left;
    logic [3:0]  cycle;
    logic [13:0] lbp_addr;
    logic        lbp_valid;
    logic        finish;

    int n_checks = 0;
    int n_fail   = 0;

    int pulses, seq_err, dup_err, onehot_err, active, stray, fin_drop;
    int er, ec;
    bit ed_left;
    bit seen [16384];
    logic [13:0] last_addr;

    lbp_scan_ctrl #(
        .IMG_W  (128),
        .AXIS_W (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
`ifdef LBP_SCAN_HOLD_EN
        .hold       (hold),
`endif
        .gray_req   (gray_req),
        .initialize (initialize),
        .right      (right),
        .down       (down),
        .left       (left),
        .cycle      (cycle),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with INIT cycle 0 on the outputs; leaves with the first CALC on the outputs.
    task automatic run_init(input string tag);
        for (int k = 0; k < 10; k++) begin
            check_eq({tag, "_init"}, 32'(initialize), 32'd1);
            check_eq({tag, "_init_cyc"}, 32'(cycle), k);
            check_eq({tag, "_init_req"}, 32'(gray_req), 32'(k < 9));
            step();
        end
        check_eq({tag, "_calc_vld"}, 32'(lbp_valid), 32'd1);
        check_eq({tag, "_calc_addr"}, 32'(lbp_addr), 32'd129);
        check_eq({tag, "_calc_cyc"}, 32'(cycle), 32'd0);
        check_eq({tag, "_calc_req"}, 32'(gray_req), 32'd0);
        check_eq({tag, "_calc_init"}, 32'(initialize), 32'd0);
    endtask

    // Step until lbp_valid shows the given center, within a cycle budget.
    task automatic wait_center(input string tag, input logic [13:0] addr);
        for (int i = 0; i < 2000 && !(lbp_valid && lbp_addr == addr); i++) step();
        check_eq(tag, 32'(lbp_valid && lbp_addr == addr), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        gray_ready = 1'b0;
`ifdef LBP_SCAN_HOLD_EN
        hold       = 1'b0;
`endif
        step();
        step();
        step();
        check_eq("rst_cycle", 32'(cycle), 32'd0);
        check_eq("rst_addr", 32'(lbp_addr), 32'd129);
        check_eq("rst_strobes", 32'({gray_req, initialize, right, down, left, lbp_valid}), 32'd0);
        check_eq("rst_finish", 32'(finish), 32'd0);
        reset = 1'b0;
        step();
        step();
        check_eq("idle_wait", 32'(initialize), 32'd0);

        // Scenario 1: start-up and first result
        gray_ready = 1'b1;
        step();
        gray_ready = 1'b0;
        run_init("s1");

        // Scenario 2: first right move keeps the old center as base
        step();
        for (int k = 0; k < 4; k++) begin
            check_eq("s2_right", 32'(right), 32'd1);
            check_eq("s2_cyc", 32'(cycle), k);
            check_eq("s2_addr", 32'(lbp_addr), 32'd129);
            check_eq("s2_req", 32'(gray_req), 32'(k < 3));
            step();
        end
        check_eq("s2_vld", 32'(lbp_valid), 32'd1);
        check_eq("s2_addr_next", 32'(lbp_addr), 32'd130);

`ifdef LBP_SCAN_HOLD_EN
        // Scenario 6: hold in the middle of a right move
        step();
        step();
        check_eq("s6_pre_cyc", 32'(cycle), 32'd1);
        hold = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("s6_hold_right", 32'(right), 32'd0);
            check_eq("s6_hold_req", 32'(gray_req), 32'd0);
            check_eq("s6_hold_cyc", 32'(cycle), 32'd1);
            step();
        end
        hold = 1'b0;
        #1;
        for (int k = 1; k < 4; k++) begin
            check_eq("s6_resume_right", 32'(right), 32'd1);
            check_eq("s6_resume_cyc", 32'(cycle), k);
            step();
        end
        check_eq("s6_vld_addr", 32'(lbp_addr), 32'd131);
`endif

        // Scenario 3: end of row 1, turn down, then head left
        wait_center("s3_reach_254", 14'd254);
        step();
        check_eq("s3_down", 32'(down), 32'd1);
        check_eq("s3_down_addr", 32'(lbp_addr), 32'd254);
        for (int i = 0; i < 4; i++) step();
        check_eq("s3_vld_382", 32'(lbp_valid), 32'd1);
        check_eq("s3_addr_382", 32'(lbp_addr), 32'd382);
        step();
        check_eq("s3_left", 32'(left), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check_eq("s3_vld_381", 32'(lbp_valid), 32'd1);
        check_eq("s3_addr_381", 32'(lbp_addr), 32'd381);

        // Scenario 5: reset during the row-2 -> row-3 down move, cycle 2
        wait_center("s5_reach_257", 14'd257);
        step();
        step();
        step();
        check_eq("s5_down_cyc2", 32'({down, cycle}), 32'h12);
        reset = 1'b1;
        step();
        check_eq("s5_strobes", 32'({gray_req, initialize, right, down, left, lbp_valid, finish}), 32'd0);
        check_eq("s5_cycle", 32'(cycle), 32'd0);
        check_eq("s5_addr", 32'(lbp_addr), 32'd129);
        reset = 1'b0;
        step();
        gray_ready = 1'b1;
        step();
        gray_ready = 1'b0;
        run_init("s5_rerun");

        // Scenario 4: full scan from the first result to finish
        pulses = 0; seq_err = 0; dup_err = 0; onehot_err = 0; active = 0;
        er = 1; ec = 1; ed_left = 1'b0; last_addr = '0;
        for (int t = 0; t < 80000 && !finish; t++) begin
            if ($countones({initialize, right, down, left}) > 1) onehot_err++;
            if (initialize || right || down || left || lbp_valid) active++;
            if (lbp_valid) begin
                pulses++;
                if (lbp_addr != 14'(er * 128 + ec)) seq_err++;
                if (seen[lbp_addr]) dup_err++;
                seen[lbp_addr] = 1'b1;
                last_addr = lbp_addr;
                if (!ed_left) begin
                    if (ec < 126) ec++;
                    else begin er++; ed_left = 1'b1; end
                end else begin
                    if (ec > 1) ec--;
                    else begin er++; ed_left = 1'b0; end
                end
            end
            step();
        end
        check_eq("s4_finish", 32'(finish), 32'd1);
        check_eq("s4_pulses", pulses, 32'd15876);
        check_eq("s4_order_err", seq_err, 32'd0);
        check_eq("s4_dup_addr", dup_err, 32'd0);
        check_eq("s4_onehot_err", onehot_err, 32'd0);
        check_eq("s4_last_addr", 32'(last_addr), 32'd16129);
        check_eq("s4_active_cycles", active, 32'(15876 + 4 * 15875));

        stray = 0; fin_drop = 0;
        gray_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (gray_req || initialize || right || down || left || lbp_valid) stray++;
            if (!finish) fin_drop++;
            step();
        end
        gray_ready = 1'b0;
        check_eq("s4_no_strobes", stray, 32'd0);
        check_eq("s4_finish_sticky", fin_drop, 32'd0);
        check_eq("s4_done_cycle", 32'(cycle), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
